// File: rtl/log_div_pipe.sv
// Three-stage Mitchell logarithmic divider: signed 2W-bit dividend over W-bit divisor.
// Operands move through the log domain; all stages advance together on a shared enable.
module log_div_pipe #(
    parameter int DWIDTH      = 16,
    parameter int TRUNC_WIDTH = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [2*DWIDTH-1:0]   i_a,
    input  logic [DWIDTH-1:0]     i_b,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DWIDTH-1:0]     o_z,
    output logic                  o_sat,
    output logic                  o_dz
);

    localparam int AW  = 2 * DWIDTH;
    localparam int F   = DWIDTH;
    localparam int KAW = $clog2(AW);
    localparam int KBW = $clog2(DWIDTH);
    localparam int EW  = KAW + 2;
    localparam int MW  = AW + 2;

    localparam logic [F-1:0]  TMASK = {F{1'b1}} << TRUNC_WIDTH;
    localparam logic [MW-1:0] PMAX  = MW'(2 ** (DWIDTH - 1) - 1);
    localparam logic [MW-1:0] NMAG  = MW'(2 ** (DWIDTH - 1));

    function automatic logic [KAW-1:0] lead_a(input logic [AW-1:0] v);
        lead_a = '0;
        for (int i = 0; i < AW; i++)
            if (v[i]) lead_a = i[KAW-1:0];
    endfunction

    function automatic logic [KBW-1:0] lead_b(input logic [DWIDTH-1:0] v);
        lead_b = '0;
        for (int i = 0; i < DWIDTH; i++)
            if (v[i]) lead_b = i[KBW-1:0];
    endfunction

    logic en;
    assign en      = !o_valid || i_ready;
    assign o_ready = en;

    // Stage 1: sign, magnitudes and leading-one positions
    logic [AW-1:0]     a_abs;
    logic [DWIDTH-1:0] b_abs;

    always_comb begin
        a_abs = i_a[AW-1] ? -i_a : i_a;
        b_abs = i_b[DWIDTH-1] ? -i_b : i_b;
    end

    logic              v1, s1_s, s1_za, s1_zb;
    logic [AW-1:0]     s1_a;
    logic [DWIDTH-1:0] s1_b;
    logic [KAW-1:0]    s1_ka;
    logic [KBW-1:0]    s1_kb;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v1    <= 1'b0;
            s1_s  <= 1'b0;
            s1_za <= 1'b0;
            s1_zb <= 1'b0;
            s1_a  <= '0;
            s1_b  <= '0;
            s1_ka <= '0;
            s1_kb <= '0;
        end else if (en) begin
            v1 <= i_valid;
            if (i_valid) begin
                s1_s  <= i_a[AW-1] ^ i_b[DWIDTH-1];
                s1_za <= (i_a == '0);
                s1_zb <= (i_b == '0);
                s1_a  <= a_abs;
                s1_b  <= b_abs;
                s1_ka <= lead_a(a_abs);
                s1_kb <= lead_b(b_abs);
            end
        end
    end

    // Stage 2: fraction subtraction; the borrow moves one unit into the exponent
    logic [KAW:0]      sha;
    logic [KBW:0]      shb;
    logic [AW-1:0]     na;
    logic [DWIDTH-1:0] nb;
    logic [F-1:0]      xa, xb;
    logic              lt;
    logic [F+1:0]      m_n;
    logic signed [EW-1:0] e_n;

    always_comb begin
        sha = (KAW + 1)'(AW) - {1'b0, s1_ka};
        shb = (KBW + 1)'(DWIDTH) - {1'b0, s1_kb};
        na  = s1_a << sha;
        nb  = s1_b << shb;
        xa  = F'(na >> (AW - F)) & TMASK;
        xb  = nb & TMASK;
        lt  = xa < xb;
        m_n = {2'b01, xa - xb};
        e_n = EW'(s1_ka) - EW'(s1_kb) - EW'(lt);
    end

    logic                 v2, s2_s, s2_za, s2_zb;
    logic [F+1:0]         s2_m;
    logic signed [EW-1:0] s2_e;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v2    <= 1'b0;
            s2_s  <= 1'b0;
            s2_za <= 1'b0;
            s2_zb <= 1'b0;
            s2_m  <= '0;
            s2_e  <= '0;
        end else if (en) begin
            v2 <= v1;
            if (v1) begin
                s2_s  <= s1_s;
                s2_za <= s1_za;
                s2_zb <= s1_zb;
                s2_m  <= m_n;
                s2_e  <= e_n;
            end
        end
    end

    // Stage 3: antilog shift, then saturate into the signed result
    logic [MW-1:0]     mag;
    logic [EW-1:0]     lsh, rsh;
    logic [DWIDTH-1:0] z_n;
    logic              sat_n, dz_n;

    always_comb begin
        lsh = s2_e - EW'(F);
        rsh = EW'(F) - s2_e;
        if (s2_e < 0)
            mag = '0;
        else if (s2_e >= F)
            mag = MW'(s2_m) << lsh;
        else
            mag = MW'(s2_m) >> rsh;

        z_n   = '0;
        sat_n = 1'b0;
        dz_n  = 1'b0;
        if (s2_zb) begin
            dz_n = 1'b1;
            z_n  = s2_s ? NMAG[DWIDTH-1:0] : PMAX[DWIDTH-1:0];
        end else if (s2_za) begin
            z_n = '0;
        end else if (!s2_s && mag > PMAX) begin
            sat_n = 1'b1;
            z_n   = PMAX[DWIDTH-1:0];
        end else if (s2_s && mag > NMAG) begin
            sat_n = 1'b1;
            z_n   = NMAG[DWIDTH-1:0];
        end else begin
            z_n = s2_s ? -mag[DWIDTH-1:0] : mag[DWIDTH-1:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_z     <= '0;
            o_sat   <= 1'b0;
            o_dz    <= 1'b0;
        end else if (en) begin
            o_valid <= v2;
            if (v2) begin
                o_z   <= z_n;
                o_sat <= sat_n;
                o_dz  <= dz_n;
            end
        end
    end

endmodule

// File: tb/tb_log_div_pipe.sv
// Bench for log_div_pipe: log-domain reference model, scoreboard and
// per-cycle output checker, driven by directed vectors, a stall stream and a reset.
module tb_log_div_pipe;

    localparam int DW = 16;
    localparam int AW = 2 * DW;
    localparam int TW = 0;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_valid = 1'b0;
    logic          i_ready = 1'b1;
    logic [AW-1:0] i_a = '0;
    logic [DW-1:0] i_b = '0;
    logic          o_ready, o_valid, o_sat, o_dz;
    logic [DW-1:0] o_z;

    log_div_pipe #(.DWIDTH(DW), .TRUNC_WIDTH(TW)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_valid(i_valid), .o_ready(o_ready),
        .i_a(i_a), .i_b(i_b),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_z(o_z), .o_sat(o_sat), .o_dz(o_dz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] z;
        bit            sat;
        bit            dz;
        int            acc;
        bit            lat;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   delivered = 0;
    bit   chk_lat = 1'b1;

    function automatic void chk(string name, longint act, longint req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endfunction

    function automatic int flog2(longint v);
        int k = 0;
        while (v > 1) begin
            v = v >> 1;
            k++;
        end
        return k;
    endfunction

    // Reference: log2 approximations, subtract in the log domain, antilog
    function automatic exp_t model(logic [AW-1:0] a, logic [DW-1:0] b);
        exp_t   r;
        longint la, lb, aa, bb, xa, xb, l, fr, mag, pmax, nmag, msk;
        int     ka, kb, e;
        bit     s;
        r.z = '0; r.sat = 0; r.dz = 0; r.acc = 0; r.lat = 0;
        pmax = (64'sd1 <<< (DW - 1)) - 1;
        nmag = 64'sd1 <<< (DW - 1);
        la = longint'($signed(a));
        lb = longint'($signed(b));
        if (lb == 0) begin
            r.dz = 1;
            r.z  = (la >= 0) ? DW'(pmax) : DW'(-nmag);
        end else if (la != 0) begin
            s   = (la < 0) != (lb < 0);
            aa  = (la < 0) ? -la : la;
            bb  = (lb < 0) ? -lb : lb;
            ka  = flog2(aa);
            kb  = flog2(bb);
            msk = ~((64'sd1 <<< TW) - 1);
            xa  = (((aa - (64'sd1 <<< ka)) <<< DW) >>> ka) & msk;
            xb  = (((bb - (64'sd1 <<< kb)) <<< DW) >>> kb) & msk;
            l   = (longint'(ka) <<< DW) + xa - (longint'(kb) <<< DW) - xb;
            e   = int'(l >>> DW);
            fr  = l & ((64'sd1 <<< DW) - 1);
            mag = (e < 0) ? 0 : ((((64'sd1 <<< DW) + fr) <<< e) >>> DW);
            if (!s && mag > pmax) begin
                r.sat = 1; r.z = DW'(pmax);
            end else if (s && mag > nmag) begin
                r.sat = 1; r.z = DW'(-nmag);
            end else begin
                r.z = s ? DW'(-mag) : DW'(mag);
            end
        end
        return r;
    endfunction

    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_z;
    logic          prev_sat, prev_dz, prev_valid;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst_n) begin
            chk("reset_outputs", {o_valid, o_sat, o_dz, o_z}, 0);
            chk("reset_ready", o_ready, 1);
            prev_stall = 1'b0;
        end else begin
            chk("ready_rule", o_ready, (!o_valid || i_ready));
            if (prev_stall) begin
                chk("hold_valid", o_valid, prev_valid);
                chk("hold_z", o_z, prev_z);
                chk("hold_flags", {o_sat, o_dz}, {prev_sat, prev_dz});
            end
            if (o_valid && i_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_valid", o_valid, 0);
                end else begin
                    e = q.pop_front();
                    chk("z", o_z, e.z);
                    chk("sat", o_sat, e.sat);
                    chk("dz", o_dz, e.dz);
                    if (e.lat) chk("latency", cyc - e.acc, 3);
                    delivered++;
                end
            end
            if (i_valid && o_ready) begin
                e = model(i_a, i_b);
                e.acc = cyc;
                e.lat = chk_lat;
                q.push_back(e);
            end
            prev_stall = o_valid && !i_ready;
            prev_valid = o_valid;
            prev_z     = o_z;
            prev_sat   = o_sat;
            prev_dz    = o_dz;
        end
    end

    task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] b);
        bit acc;
        int n = 0;
        i_a = a;
        i_b = b;
        i_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = o_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 50);
        if (!acc) chk("accept_timeout", 0, 1);
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_left", q.size(), 0);
    endtask

    task automatic pin(input logic [AW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW-1:0] z, input bit sat, input bit dz);
        exp_t r;
        r = model(a, b);
        chk("model_pin", {r.z, r.sat, r.dz}, {z, sat, dz});
        send(a, b);
        drain();
    endtask

    logic [AW-1:0] sa[8];
    logic [DW-1:0] sb[8];

    initial begin
        int d0, idx, t;
        bit acc;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        pin(32'd100, 16'd10, 16'd10, 0, 0);
        pin(-32'sd100, 16'd10, -16'sd10, 0, 0);
        pin(32'd7, 16'd2, 16'd3, 0, 0);
        pin(32'd2, 16'd3, 16'd0, 0, 0);
        pin(32'd0, 16'd5, 16'd0, 0, 0);
        pin(32'h7FFFFFFF, 16'd1, 16'd32767, 1, 0);
        pin(32'h80000000, 16'hFFFF, 16'd32767, 1, 0);
        pin(32'd5, 16'd0, 16'd32767, 0, 1);
        pin(-32'sd5, 16'd0, 16'h8000, 0, 1);
        pin(-32'sd32768, 16'd1, 16'h8000, 0, 0);
        pin(32'd32768, 16'd1, 16'd32767, 1, 0);
        pin(32'd1000, -16'sd3, 16'hFE8C, 0, 0);
        pin(-32'sd1, 16'hFFFF, 16'd1, 0, 0);

        // back-to-back stream with a two-cycle downstream stall
        for (int k = 0; k < 8; k++) begin
            sa[k] = AW'((k + 1) * 1237 + k * 40000);
            sb[k] = DW'(k + 3);
        end
        sa[5] = -sa[5];
        chk_lat = 1'b0;
        d0 = delivered;
        idx = 0;
        t = 0;
        while (idx < 8 && t < 60) begin
            i_ready = !(t == 4 || t == 5);
            i_valid = 1'b1;
            i_a = sa[idx];
            i_b = sb[idx];
            @(negedge clk);
            acc = o_ready;
            if (t == 4 || t == 5) chk("stall_ready", o_ready, 0);
            @(posedge clk);
            #1;
            if (acc) idx++;
            t++;
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        drain();
        chk("stream_count", delivered - d0, 8);
        chk_lat = 1'b1;

        // reset with three operands in flight
        for (int k = 0; k < 3; k++) begin
            i_valid = 1'b1;
            i_a = AW'(500 + k);
            i_b = 16'd7;
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
        rst_n = 1'b0;
        q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        d0 = delivered;
        repeat (5) @(posedge clk);
        #1;
        chk("post_reset_quiet", delivered - d0, 0);
        send(32'd300, 16'd12);
        drain();
        chk("post_reset_count", delivered - d0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/log_div_pipe.md
LOG_DIV_PIPE -- requirements
Module: log_div_pipe

Interface
REQ-001 SHALL have parameter DWIDTH, default 16: divisor/quotient width; dividend width is 2*DWIDTH.
REQ-002 SHALL have parameter TRUNC_WIDTH, default 0: number of LSBs of each log fraction forced to zero before subtraction.
REQ-003 SHALL have port i_clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port i_rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port i_valid, input, 1: operand pair valid.
REQ-006 SHALL have port o_ready, output, 1: block accepts operands this cycle.
REQ-007 SHALL have port i_a, input, 2*DWIDTH: signed dividend.
REQ-008 SHALL have port i_b, input, DWIDTH: signed divisor.
REQ-009 SHALL have port o_valid, output, 1: result valid.
REQ-010 SHALL have port i_ready, input, 1: downstream accepts result.
REQ-011 SHALL have port o_z, output, DWIDTH: signed approximate quotient.
REQ-012 SHALL have port o_sat, output, 1: quotient saturated; qualified by o_valid.
REQ-013 SHALL have port o_dz, output, 1: divide by zero; qualified by o_valid.

Function
REQ-014 SHALL compute a Mitchell logarithmic approximate quotient a/b; it is the inverse operation of the team's DR-ALM multiplier.
REQ-015 Stage 1 SHALL register s = sign(a) XOR sign(b), unsigned |a| (2*DWIDTH bits, -2^(2*DWIDTH-1) exact) and |b|, plus leading-one positions ka and kb.
REQ-016 Fractions SHALL be F=DWIDTH bits, left-aligned: xa = bits below the leading one of |a| (truncated to F bits); xb = bits below the leading one of |b|, zero-padded to F bits; the low TRUNC_WIDTH bits of each SHALL be zeroed.
REQ-017 Stage 2 SHALL register: if xa>=xb then m = 2^F + (xa-xb), e = ka-kb; else m = 2^(F+1) + xa - xb, e = ka-kb-1 (m is unsigned F+2 bits, e is signed).
REQ-018 Stage 3 SHALL register mag = floor(m * 2^e / 2^F), with shift-left when e>=F and shift-right otherwise; mag = 0 when e<0.
REQ-019 Saturation: s=0 and mag>2^(DWIDTH-1)-1 gives o_z = 2^(DWIDTH-1)-1 with o_sat=1; s=1 and mag>2^(DWIDTH-1) gives o_z = -2^(DWIDTH-1) with o_sat=1; otherwise o_z = s ? -mag : mag with o_sat=0.
REQ-020 a==0 with b!=0 SHALL produce o_z=0, o_sat=0, o_dz=0.
REQ-021 b==0 SHALL produce o_dz=1, o_sat=0, o_z = (a>=0) ? 2^(DWIDTH-1)-1 : -2^(DWIDTH-1).
REQ-022 Latency SHALL be exactly 3 cycles from an accepted input (i_valid & o_ready) to o_valid, with no stall.
REQ-023 Pipeline advance enable SHALL be en = !o_valid | i_ready; o_ready SHALL equal en; all stages SHALL advance only when en=1.
REQ-024 Throughput SHALL be one result per cycle; with en=0, o_z/o_sat/o_dz/o_valid SHALL hold stable and no in-flight data SHALL be lost or duplicated.
REQ-025 Bubbles (i_valid=0) SHALL propagate as per-stage valid=0 and SHALL NOT produce o_valid.
REQ-026 o_z/o_sat/o_dz SHALL update only on cycles where stage 3 loads.

Reset
REQ-027 While i_rst_n=0: o_valid=0, o_z=0, o_sat=0, o_dz=0, all stage valids cleared; o_ready=1 when deasserted.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight operands; the first o_valid after release SHALL come from an operand accepted after release.

Verification
REQ-029 a=100, b=10 -> o_z=10 after 3 cycles; a=-100, b=10 -> o_z=-10; a=7, b=2 -> o_z=3.
REQ-030 a=2, b=3 (e=-1) -> o_z=0; a=0, b=5 -> o_z=0, flags 0.
REQ-031 a=0x7FFFFFFF, b=1 -> o_z=32767, o_sat=1; a=0x80000000, b=-1 -> o_z=32767, o_sat=1.
REQ-032 a=5, b=0 -> o_z=32767, o_dz=1; a=-5, b=0 -> o_z=-32768, o_dz=1.
REQ-033 Stream 8 back-to-back operands, i_ready held low for 2 cycles mid-stream -> o_ready low during the stall, outputs held, all 8 results delivered in order, none dropped.
REQ-034 Reset pulsed with 3 operands in flight -> no o_valid from those operands; a new operand yields its result 3 cycles after acceptance.
